// File: rtl/sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch_if
// Description : Signal bundle for sprite_fetch: control (start/id/busy/done),
//               sprite RAM read port and the outgoing pixel stream.
//               Directions are named from the fetch engine's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_fetch_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 9,
   parameter int ID_WIDTH   = 5
);
   // control
   logic                  i_start;
   logic [ID_WIDTH-1:0]   i_sprite_id;
   logic                  o_busy;
   logic                  o_done;
   // sprite RAM read port
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic                  o_mem_read;
   logic [DATA_WIDTH-1:0] i_mem_data;
   logic                  i_mem_ready;
   // pixel stream
   logic [DATA_WIDTH-1:0] o_pix_data;
   logic                  o_pix_valid;
   logic                  o_pix_last;
   logic                  i_pix_ready;

   // fetch engine side
   modport master (
      input  i_start, i_sprite_id, i_mem_data, i_mem_ready, i_pix_ready,
      output o_busy, o_done, o_mem_addr, o_mem_read,
             o_pix_data, o_pix_valid, o_pix_last
   );

   // environment side (pipeline + RAM)
   modport slave (
      output i_start, i_sprite_id, i_mem_data, i_mem_ready, i_pix_ready,
      input  o_busy, o_done, o_mem_addr, o_mem_read,
             o_pix_data, o_pix_valid, o_pix_last
   );
endinterface
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch
// Description : Read-side initiator for the sprite RAM. Walks the PIXELS
//               addresses of one sprite (base = id*PIXELS, wrapping modulo
//               2^ADDR_WIDTH), issues one read strobe per pixel, captures the
//               colour word and forwards it on a valid/ready stream.
//               Optional macro SPRITE_FETCH_ABORT_EN adds i_abort, which
//               returns the engine to IDLE from any busy state without o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_fetch #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 9,
   parameter int ID_WIDTH   = 5,
   parameter int PIXELS     = 400
) (
   input  wire logic      i_clk,
   input  wire logic      i_rst_n,
`ifdef SPRITE_FETCH_ABORT_EN
   input  wire logic      i_abort,
`endif
   sprite_fetch_if.master bus
);

   localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_CAPTURE = 3'd3,
      S_PUSH    = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_pix_data;
   logic [ID_WIDTH-1:0]   w_id;
   logic [ADDR_WIDTH-1:0] w_base;
   logic                  w_last;
   logic                  w_abort;

   // Base address is the sprite index times the sprite size; overflow past
   // the RAM size simply wraps, so truncation is the intended behaviour.
   assign w_id   = bus.i_sprite_id;
   assign w_base = ADDR_WIDTH'(32'(w_id) * 32'(PIXELS));
   assign w_last = (r_count == LAST_IDX);

`ifdef SPRITE_FETCH_ABORT_EN
   assign w_abort = i_abort;
`else
   assign w_abort = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides everything, including a handshake
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.i_start) w_state_nxt = S_SETUP;
         S_SETUP:   w_state_nxt = S_STROBE;
         S_STROBE:  if (bus.i_mem_ready) w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_PUSH;
         S_PUSH:    if (bus.i_pix_ready) w_state_nxt = w_last ? S_DONE : S_SETUP;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
      if (w_abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Address/counter/data path; qualifying on the next state keeps the
   // counter untouched when an abort wins over a handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr     <= '0;
         r_count    <= '0;
         r_pix_data <= '0;
      end else begin
         if ((r_state == S_IDLE) && (w_state_nxt == S_SETUP)) begin
            r_addr  <= w_base;
            r_count <= '0;
         end else if ((r_state == S_PUSH) && (w_state_nxt == S_SETUP)) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
         end
         if (r_state == S_CAPTURE) begin
            r_pix_data <= bus.i_mem_data;
         end
      end
   end

   // Outputs decode directly from registered state so reset clears them at once
   assign bus.o_busy      = (r_state != S_IDLE);
   assign bus.o_done      = (r_state == S_DONE);
   assign bus.o_mem_read  = (r_state == S_STROBE);
   assign bus.o_mem_addr  = r_addr;
   assign bus.o_pix_data  = r_pix_data;
   assign bus.o_pix_valid = (r_state == S_PUSH);
   assign bus.o_pix_last  = (r_state == S_PUSH) && w_last;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_fetch
// Description : Self-checking bench for sprite_fetch. RAM model returns
//               addr[8:0]; a table of fetch scenarios drives backpressure and
//               RAM wait, plus hand sequences for reset/abort mid-fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch;

   localparam int ADDR_WIDTH = 14;
   localparam int DATA_WIDTH = 9;
   localparam int ID_WIDTH   = 5;
   localparam int PIXELS     = 400;
   localparam int LIMIT      = 4 * PIXELS + 100;

   logic clk = 1'b0;
   logic rst_n;
`ifdef SPRITE_FETCH_ABORT_EN
   logic abort;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   sprite_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

   sprite_fetch #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .ID_WIDTH(ID_WIDTH), .PIXELS(PIXELS)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
`ifdef SPRITE_FETCH_ABORT_EN
      .i_abort (abort),
`endif
      .bus     (bus)
   );

   // RAM model: data word equals the low 9 address bits
   assign bus.i_mem_data = bus.o_mem_addr[8:0];

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int bp_pix;
      int bp_len;
      int wt_pix;
      int wt_len;
      int ign_pix;
      int exp_done;
      int exp_first;
      int exp_pulses;
      int exp_run;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {4'd0, bus.o_busy, bus.o_done, bus.o_mem_addr, bus.o_mem_read,
              bus.o_pix_data, bus.o_pix_valid, bus.o_pix_last};
   endfunction

   // kill_mode: 0 run to completion, 1 reset at kill_pix, 2 abort at kill_pix
   task automatic run_fetch(input int id, input int bp_pix, input int bp_len,
                            input int wt_pix, input int wt_len, input int ign_pix,
                            input int kill_mode, input int kill_pix,
                            output int done_cyc, output int first_valid,
                            output int pulses, output int max_run, output int hs);
      int  base, cyc, bp_left, wt_left, run, ea;
      bit  prev_rd, fin;
      base = (id * PIXELS) % (1 << ADDR_WIDTH);
      done_cyc = -1; first_valid = -1; pulses = 0; max_run = 0; hs = 0;
      run = 0; prev_rd = 1'b0; fin = 1'b0;
      bp_left = bp_len; wt_left = wt_len;
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_sprite_id = ID_WIDTH'(id);
      bus.i_pix_ready = 1'b1; bus.i_mem_ready = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      cyc = 1;
      while (!fin) begin
         ea = (base + hs) % (1 << ADDR_WIDTH);
         if (bus.o_mem_read) begin
            if (!prev_rd) pulses++;
            run++;
            if (run > max_run) max_run = run;
            check("strobe_addr", 32'(bus.o_mem_addr), 32'(ea));
         end else begin
            run = 0;
         end
         prev_rd = bus.o_mem_read;
         if (bus.o_pix_valid) begin
            if (first_valid < 0) first_valid = cyc;
            check("pix_data", 32'(bus.o_pix_data), 32'(ea % 512));
            check("push_addr", 32'(bus.o_mem_addr), 32'(ea));
            check("pix_last", 32'(bus.o_pix_last), 32'(hs == PIXELS - 1));
         end else begin
            check("last_idle", 32'(bus.o_pix_last), 32'd0);
         end
         if (bus.o_done) begin
            done_cyc = cyc;
            fin = 1'b1;
         end
         // inputs for the coming edge
         bus.i_start = 1'b0;
         bus.i_mem_ready = 1'b1;
         if (bus.o_mem_read && hs == wt_pix && wt_left > 0) begin
            bus.i_mem_ready = 1'b0;
            wt_left--;
         end
         bus.i_pix_ready = 1'b1;
         if (bus.o_pix_valid && hs == bp_pix && bp_left > 0) begin
            bus.i_pix_ready = 1'b0;
            bp_left--;
         end
         if (bus.o_pix_valid && hs == ign_pix) begin
            bus.i_start = 1'b1;
            bus.i_sprite_id = '0;
         end
         if (kill_mode != 0 && bus.o_pix_valid && hs == kill_pix) begin
            fin = 1'b1;
            if (kill_mode == 1) begin
               rst_n = 1'b0;
               #1;
               check("rst_outs_zero", all_outs(), 32'd0);
               repeat (2) begin
                  @(negedge clk);
                  check("rst_hold_zero", all_outs(), 32'd0);
               end
               rst_n = 1'b1;
            end
`ifdef SPRITE_FETCH_ABORT_EN
            else begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               check("abort_busy", 32'(bus.o_busy), 32'd0);
               check("abort_valid", 32'(bus.o_pix_valid), 32'd0);
               check("abort_read", 32'(bus.o_mem_read), 32'd0);
               repeat (3) begin
                  check("abort_no_done", 32'(bus.o_done), 32'd0);
                  @(negedge clk);
               end
            end
`endif
         end else if (bus.o_pix_valid && bus.i_pix_ready) begin
            hs++;
         end
         if (!fin) begin
            if (cyc >= LIMIT) begin
               n_assert++;
               n_fail++;
               $display("FAIL fetch_timeout: got no o_done after %0d cycles, required one", cyc);
               fin = 1'b1;
            end else begin
               @(negedge clk);
               cyc++;
            end
         end
      end
      bus.i_start = 1'b0;
      if (done_cyc > 0) begin
         @(negedge clk);
         check("done_pulse_end", 32'(bus.o_done), 32'd0);
         check("idle_after_done", 32'(bus.o_busy), 32'd0);
      end
   endtask

   vec_t vecs[4];

   initial begin
      int dc, fv, pl, mr, hs;

      // id, bp_pix, bp_len, wt_pix, wt_len, ign_pix, done, first, pulses, run
      vecs[0] = '{3,  -1, 0, -1, 0, -1,  1601, 4, 400, 1};  // plain fetch
      vecs[1] = '{3,   7, 5, -1, 0, -1,  1606, 4, 400, 1};  // 5 cycles stall on pixel 7
      vecs[2] = '{3,  -1, 0,  0, 2, -1,  1603, 6, 400, 3};  // 2-cycle RAM wait on pixel 0
      vecs[3] = '{31, -1, 0, -1, 0, 100, 1601, 4, 400, 1};  // top sprite + ignored start

      rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_sprite_id = '0;
      bus.i_pix_ready = 1'b1; bus.i_mem_ready = 1'b1;
`ifdef SPRITE_FETCH_ABORT_EN
      abort = 1'b0;
`endif

      // reset then idle
      repeat (3) @(negedge clk);
      check("in_reset_zero", all_outs(), 32'd0);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_outs_zero", all_outs(), 32'd0);
      end

      // table-driven fetch scenarios
      for (int i = 0; i < 4; i++) begin
         run_fetch(vecs[i].id, vecs[i].bp_pix, vecs[i].bp_len, vecs[i].wt_pix,
                   vecs[i].wt_len, vecs[i].ign_pix, 0, -1, dc, fv, pl, mr, hs);
         check("done_cycle", 32'(dc), 32'(vecs[i].exp_done));
         check("first_valid", 32'(fv), 32'(vecs[i].exp_first));
         check("read_pulses", 32'(pl), 32'(vecs[i].exp_pulses));
         check("read_max_len", 32'(mr), 32'(vecs[i].exp_run));
         check("handshakes", 32'(hs), 32'(PIXELS));
      end

      // reset mid-fetch at pixel 50, then a fresh fetch
      run_fetch(5, -1, 0, -1, 0, -1, 1, 50, dc, fv, pl, mr, hs);
      check("rst_no_done", 32'(dc), 32'hFFFF_FFFF);
      check("rst_hs_count", 32'(hs), 32'd50);
      run_fetch(3, -1, 0, -1, 0, -1, 0, -1, dc, fv, pl, mr, hs);
      check("post_rst_done", 32'(dc), 32'd1601);
      check("post_rst_hs", 32'(hs), 32'(PIXELS));

`ifdef SPRITE_FETCH_ABORT_EN
      // abort at pixel 50 wins over the simultaneous handshake
      run_fetch(7, -1, 0, -1, 0, -1, 2, 50, dc, fv, pl, mr, hs);
      check("abort_done_none", 32'(dc), 32'hFFFF_FFFF);
      run_fetch(1, -1, 0, -1, 0, -1, 0, -1, dc, fv, pl, mr, hs);
      check("post_abort_done", 32'(dc), 32'd1601);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
